// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
//
// Purpose:
//   Shared types and constants for the 9-bit processor control sequencer.
//   Holds the sequencer state encoding, the instruction-class encoding
//   produced by the decoder, the 3-bit opcode values and the HALT
//   instruction pattern.
//
// Ports:
//   (package, no ports)
// ---------------------------------------------------------------------------
package alu_seq_pkg;

    // Sequencer states. IDLE and HALT are the two resting states; every
    // other state counts as busy.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } seqState_e;

    // What the sequencer does after EXEC (or DECODE, for HALT).
    typedef enum logic [1:0] {
        CLS_WB     = 2'd0,
        CLS_BRANCH = 2'd1,
        CLS_MEM    = 2'd2,
        CLS_HALT   = 2'd3
    } instrClass_e;

    // Opcodes carried in instr[8:6].
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_XOR = 3'b001;
    localparam logic [2:0] OP_SLT = 3'b010;
    localparam logic [2:0] OP_BNZ = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;
    localparam logic [2:0] OP_LW  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    // Rotate r0 by 0 does nothing useful, so the ISA reuses it as HALT.
    localparam logic [8:0] HALT_INSTR = 9'b101_000_000;

    // Pulls the opcode field out of an instruction word.
    function automatic logic [2:0] opcodeOf(input logic [8:0] instrWord);
        return instrWord[8:6];
    endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// ---------------------------------------------------------------------------
// alu_seq_decode
//
// Purpose:
//   Purely combinational decoder. Classifies the held instruction register
//   into the path the sequencer takes after EXEC (write-back, branch,
//   memory, halt) and reports whether the instruction writes the register
//   file, plus the few per-opcode flags the sequencer needs.
//
// Ports:
//   ir_i        in   9  instruction register contents
//   class_o     out  2  instruction class (instrClass_e)
//   wrIntent_o  out  1  instruction ends with a register-file write
//   isAdd_o     out  1  add: updates the shift-carry flag
//   isLoad_o    out  1  load: write-back takes memory data
//   isStore_o   out  1  store: memory request is a write
// ---------------------------------------------------------------------------
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [8:0]  ir_i,
    output instrClass_e class_o,
    output logic        wrIntent_o,
    output logic        isAdd_o,
    output logic        isLoad_o,
    output logic        isStore_o
);

    logic [2:0] opcode;

    assign opcode = opcodeOf(ir_i);

    // HALT is checked before the opcode table because it shares the rotate
    // opcode; any other rotate is an ordinary ALU op. Logic ops, slt, rotate
    // and add all finish with a register write, load writes memory data back,
    // while bnz and store never touch the register file.
    always_comb begin
        class_o    = CLS_WB;
        wrIntent_o = 1'b0;
        isAdd_o    = 1'b0;
        isLoad_o   = 1'b0;
        isStore_o  = 1'b0;
        if (ir_i == HALT_INSTR) begin
            class_o = CLS_HALT;
        end else begin
            case (opcode)
                OP_AND, OP_XOR, OP_SLT, OP_ROR: begin
                    class_o    = CLS_WB;
                    wrIntent_o = 1'b1;
                end
                OP_ADD: begin
                    class_o    = CLS_WB;
                    wrIntent_o = 1'b1;
                    isAdd_o    = 1'b1;
                end
                OP_BNZ: begin
                    class_o = CLS_BRANCH;
                end
                OP_LW: begin
                    class_o    = CLS_MEM;
                    wrIntent_o = 1'b1;
                    isLoad_o   = 1'b1;
                end
                OP_SW: begin
                    class_o   = CLS_MEM;
                    isStore_o = 1'b1;
                end
                default: begin
                    class_o = CLS_WB;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//
// Purpose:
//   Multi-cycle control sequencer for the 9-bit processor. Fetches an
//   instruction, decodes it, drives the combinational ALU's command,
//   register selects and lookup immediate for one EXEC cycle, then either
//   writes back, branches, or runs a data-memory handshake. Owns the program
//   counter and the shift-carry flag; it is the only writer of the PC.
//
// Configuration:
//   DMEM_TIMEOUT_EN  when defined, a memory access that sees no ack within
//                    TIMEOUT cycles is abandoned: the request drops, the
//                    sticky err flag sets and the sequencer halts. When
//                    undefined, MEM waits indefinitely and err is tied 0.
//
// Parameters:
//   D        program counter width (at least 9, to hold a branch target)
//   TIMEOUT  memory wait limit in cycles, 1..15 (DMEM_TIMEOUT_EN only)
//
// Ports:
//   clk           in   1  system clock, rising edge
//   reset_n       in   1  synchronous active-low reset
//   start         in   1  begin execution at pc 0 (from IDLE/HALT only)
//   instr         in   9  instruction at imem_addr, valid same cycle
//   alu_rslt      in   8  ALU result (branch target / memory address)
//   alu_prog_bit  in   1  ALU branch target bit 8
//   alu_sc_o      in   1  ALU shift-carry out
//   dmem_ack      in   1  data-memory completion pulse
//   imem_addr     out  D  current pc
//   alu_cmd       out  3  opcode during EXEC, else 0
//   ra_addr       out  3  ir[5:3] during EXEC, else 0
//   rb_addr       out  3  ir[2:0] during EXEC, else 0
//   lookup        out  3  ir[2:0] during EXEC, else 0
//   sc_i          out  1  registered shift-carry flag
//   rf_we         out  1  register-file write strobe (WB)
//   rf_waddr      out  3  write destination ir[5:3] while rf_we, else 0
//   wb_sel        out  1  0 = ALU result, 1 = dmem read data
//   dmem_req      out  1  memory request, held until ack
//   dmem_we       out  1  1 = store
//   busy          out  1  high outside IDLE/HALT
//   done          out  1  one-cycle pulse on HALT entry
//   err           out  1  sticky memory timeout flag
// ---------------------------------------------------------------------------
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int D       = 12,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [8:0]   instr,
    input  logic [7:0]   alu_rslt,
    input  logic         alu_prog_bit,
    input  logic         alu_sc_o,
    input  logic         dmem_ack,
    output logic [D-1:0] imem_addr,
    output logic [2:0]   alu_cmd,
    output logic [2:0]   ra_addr,
    output logic [2:0]   rb_addr,
    output logic [2:0]   lookup,
    output logic         sc_i,
    output logic         rf_we,
    output logic [2:0]   rf_waddr,
    output logic         wb_sel,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic         busy,
    output logic         done,
    output logic         err
);

    seqState_e    state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic [8:0]   ir_q, ir_d;
    logic         sc_q, sc_d;
    logic         done_q, done_d;

    instrClass_e  irClass;
    logic         wrIntent;
    logic         isAdd;
    logic         isLoad;
    logic         isStore;

    logic [D-1:0] pcInc;
    logic [D-1:0] pcBranch;

`ifdef DMEM_TIMEOUT_EN
    logic         err_q, err_d;
    logic [3:0]   waitCnt_q, waitCnt_d;
`endif

    alu_seq_decode uDecode (
        .ir_i       (ir_q),
        .class_o    (irClass),
        .wrIntent_o (wrIntent),
        .isAdd_o    (isAdd),
        .isLoad_o   (isLoad),
        .isStore_o  (isStore)
    );

    // PC increment wraps naturally at 2^D. A branch target is the 9-bit
    // value the ALU assembles from prog_bit and rslt, zero-extended; on a
    // not-taken branch the ALU itself supplies pc+1, so no special case.
    assign pcInc    = pc_q + D'(1);
    assign pcBranch = D'({alu_prog_bit, alu_rslt});

    // Next-state logic. Everything holds by default; each state overrides
    // only what it changes. The data-memory address is captured by the
    // datapath from alu_rslt during EXEC, so this block only sequences the
    // handshake. With the timeout enabled, an ack on the final allowed
    // cycle still completes the access normally.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        sc_d    = sc_q;
        done_d  = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        err_d     = err_q;
        waitCnt_d = waitCnt_q;
`endif
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                    sc_d    = 1'b0;
`ifdef DMEM_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_FETCH: begin
                ir_d    = instr;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (irClass == CLS_HALT) begin
                    state_d = ST_HALT;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (irClass)
                    CLS_WB: begin
                        if (isAdd) begin
                            sc_d = alu_sc_o;
                        end
                        state_d = ST_WB;
                    end
                    CLS_BRANCH: begin
                        pc_d    = pcBranch;
                        state_d = ST_FETCH;
                    end
                    CLS_MEM: begin
                        state_d = ST_MEM;
`ifdef DMEM_TIMEOUT_EN
                        waitCnt_d = 4'd0;
`endif
                    end
                    default: begin
                        state_d = ST_HALT;
                        done_d  = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (isStore) begin
                        pc_d    = pcInc;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
`ifdef DMEM_TIMEOUT_EN
                else if (waitCnt_q == 4'(TIMEOUT - 1)) begin
                    state_d = ST_HALT;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q + 4'd1;
                end
`endif
            end
            ST_WB: begin
                pc_d    = pcInc;
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register. Reset wins over everything, including an access in
    // flight, so dmem_req falls on the cycle after reset is sampled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            sc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            sc_q    <= sc_d;
            done_q  <= done_d;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    // Timeout bookkeeping: the wait counter restarts on every MEM entry and
    // err stays set until reset or the next start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_q     <= 1'b0;
            waitCnt_q <= 4'd0;
        end else begin
            err_q     <= err_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Output decode from the registered state. The ALU controls are only
    // meaningful in EXEC and sit at 0 otherwise so the ALU sees a quiet
    // command outside its one active cycle.
    always_comb begin
        alu_cmd  = 3'b000;
        ra_addr  = 3'b000;
        rb_addr  = 3'b000;
        lookup   = 3'b000;
        rf_we    = 1'b0;
        rf_waddr = 3'b000;
        wb_sel   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        if (state_q == ST_EXEC) begin
            alu_cmd = ir_q[8:6];
            ra_addr = ir_q[5:3];
            rb_addr = ir_q[2:0];
            lookup  = ir_q[2:0];
        end
        if (state_q == ST_WB && wrIntent) begin
            rf_we    = 1'b1;
            rf_waddr = ir_q[5:3];
            wb_sel   = isLoad;
        end
        if (state_q == ST_MEM) begin
            dmem_req = 1'b1;
            dmem_we  = isStore;
        end
    end

    assign imem_addr = pc_q;
    assign sc_i      = sc_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign done      = done_q;

endmodule
